alu_share_ctrl: RTL

Sequencing and arbitration controller that shares the single combinational 16-bit ALU between two requesters: port 0 is the execute stage and port 1 is the address/branch-offset unit. It accepts one operation at a time through a valid/ready handshake and arbitrates round-robin between the two ports. It drives the ALU from registered operands, returns the result on the granted port's response channel, and owns the architectural N/V/Z flag register.

---
 rtl/alu_ctrl_pkg.sv | 49 ++++
 rtl/rr_arb2.sv | 21 ++
 rtl/alu_share_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sharing controller: opcodes, FSM states,
// flag bit positions and the flag-update rule applied when a result is captured.
package alu_ctrl_pkg;

    localparam int unsigned DATA_W = 16;

    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_RED    = 3'b010,
        OP_XOR    = 3'b011,
        OP_SLL    = 3'b100,
        OP_SRA    = 3'b101,
        OP_ROR    = 3'b110,
        OP_PADDSB = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Arithmetic ops own all three flags, logic/shift ops only Z, RED/PADDSB none.
    function automatic logic [2:0] next_flags(input alu_op_e             op,
                                              input logic [DATA_W-1:0]   res,
                                              input logic                ovf,
                                              input logic [2:0]          cur);
        logic [2:0] f;
        f = cur;
        case (op)
            OP_ADD, OP_SUB: begin
                f[FLAG_N] = res[DATA_W-1];
                f[FLAG_V] = ovf;
                f[FLAG_Z] = (res == '0);
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                f[FLAG_Z] = (res == '0);
            end
            default: ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// port that was not granted last time.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between the execute stage (port 0) and the
// address unit (port 1): IDLE accepts, EXEC captures the result, RESP returns it.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req0_wrflags,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    input  logic             req1_wrflags,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,

    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [2:0]       alu_flags,

    output logic [2:0]       flags_q
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    alu_op_e          op_q, op_d;
    logic             wrflags_q, wrflags_d;
    logic             port_q, port_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       flags_d;
    logic [1:0]       gnt;

    // The ALU's own N and Z are not trusted; only its overflow bit is consumed.
    logic unused_alu_flags;
    assign unused_alu_flags = alu_flags[FLAG_N] ^ alu_flags[FLAG_Z];

    rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        wrflags_d    = wrflags_q;
        port_d       = port_q;
        result_d     = result_q;
        flags_d      = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    a_d          = gnt[1] ? req1_a       : req0_a;
                    b_d          = gnt[1] ? req1_b       : req0_b;
                    op_d         = alu_op_e'(gnt[1] ? req1_op : req0_op);
                    wrflags_d    = gnt[1] ? req1_wrflags : req0_wrflags;
                    port_d       = gnt[1];
                    last_grant_d = gnt[1];
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                if (wrflags_q) begin
                    flags_d = next_flags(op_q, alu_result, alu_flags[FLAG_V], flags_q);
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (port_q ? rsp1_ready : rsp0_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_ADD;
            wrflags_q    <= 1'b0;
            port_q       <= 1'b0;
            result_q     <= '0;
            flags_q      <= 3'b000;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            wrflags_q    <= wrflags_d;
            port_q       <= port_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
        end
    end

    assign req0_ready = (state_q == ST_IDLE) && gnt[0];
    assign req1_ready = (state_q == ST_IDLE) && gnt[1];
    assign rsp0_valid = (state_q == ST_RESP) && !port_q;
    assign rsp1_valid = (state_q == ST_RESP) &&  port_q;
    assign rsp_data   = result_q;

    // Operand registers only change on acceptance, so the ALU inputs stay quiet
    // outside of an operation.
    assign alu_in1 = a_q;
    assign alu_in2 = b_q;
    assign alu_op  = op_q;

endmodule
